// File: rtl/laser_pkg.sv
// Shared types and constants for the laser measurement scheduler.
// Holds the FSM state encoding, request-source codes and default width.
package laser_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FIRE = 3'd1,
    S_WAIT = 3'd2,
    S_GAPW = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic SRC_MAN  = 1'b0;
  localparam logic SRC_AUTO = 1'b1;

  localparam int unsigned DW_DEF = 16;

endpackage

// File: rtl/laser_period_timer.sv
// Free-running auto-request counter, 0..PERIOD-1 while enabled.
// Ports: Clk, Rst (sync, high), En_i (level), Tc_o (terminal count).
module laser_period_timer #(
  parameter int unsigned PERIOD = 50000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic En_i,
  output logic Tc_o
);

  localparam int unsigned CW =
    (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign Tc_o = En_i && (cnt_q == CW'(PERIOD - 1));

  // Disable parks the count at zero so a
  // re-enable always waits a full period.
  always_comb begin
    cnt_d = cnt_q;
    if (!En_i)
      cnt_d = '0;
    else if (Tc_o)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/laser_meas_sched.sv
// Shares the rangefinder core between manual and auto requests,
// averages 2^NAVG_LOG2 samples per measurement, flags timeouts.
// Ports: Clk/Rst (sync, high); Man_Req, Auto_En requests;
// Rf_B trigger, Rf_Done/Rf_D core reply; Busy, Dist, Dist_Valid,
// Src (0 manual, 1 auto), Err (timeout pulse).
module laser_meas_sched
  import laser_pkg::*;
#(
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned NAVG_LOG2 = 2,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned GAP       = 2,
  parameter int unsigned PERIOD    = 50000
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Man_Req,
  input  logic          Auto_En,
  output logic          Rf_B,
  input  logic          Rf_Done,
  input  logic [DW-1:0] Rf_D,
  output logic          Busy,
  output logic [DW-1:0] Dist,
  output logic          Dist_Valid,
  output logic          Src,
  output logic          Err
);

  localparam int unsigned AW   = DW + NAVG_LOG2;
  localparam int unsigned NS   = 1 << NAVG_LOG2;
  localparam int unsigned SW   = NAVG_LOG2 + 1;
  localparam int unsigned TMAX =
    (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  state_e        state_q, state_d;
  logic          man_q, man_d;
  logic          auto_q, auto_d;
  logic          gsrc_q, gsrc_d;
  logic [AW-1:0] sum_q, sum_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dist_q, dist_d;
  logic          src_q, src_d;

  logic auto_tc;
  logic grant_m;
  logic grant_a;
  logic tmo_hit;
  logic last_smp;

  laser_period_timer #(
    .PERIOD(PERIOD)
  ) u_tmr (
    .Clk (Clk),
    .Rst (Rst),
    .En_i(Auto_En),
    .Tc_o(auto_tc)
  );

  assign grant_m  = (state_q == S_IDLE) && man_q;
  assign grant_a  = (state_q == S_IDLE) && !man_q
                    && auto_q;
  assign tmo_hit  = cnt_q == TW'(TIMEOUT - 1);
  assign last_smp = scnt_q == SW'(NS - 1);

  // A new request in the grant cycle wins over
  // the clear, so it is never lost.
  always_comb begin
    state_d = state_q;
    man_d   = Man_Req | (man_q & ~grant_m);
    auto_d  = Auto_En & (auto_tc | (auto_q & ~grant_a));
    gsrc_d  = gsrc_q;
    sum_d   = sum_q;
    scnt_d  = scnt_q;
    cnt_d   = cnt_q;
    dist_d  = dist_q;
    src_d   = src_q;
    unique case (state_q)
      S_IDLE: begin
        if (man_q || auto_q) begin
          state_d = S_FIRE;
          gsrc_d  = man_q ? SRC_MAN : SRC_AUTO;
          sum_d   = '0;
          scnt_d  = '0;
        end
      end
      S_FIRE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Reply beats expiry when both land together.
        if (Rf_Done) begin
          sum_d  = sum_q + AW'(Rf_D);
          scnt_d = scnt_q + 1'b1;
          cnt_d  = '0;
          if (last_smp) begin
            state_d = S_DONE;
            dist_d  = DW'(sum_d >> NAVG_LOG2);
            src_d   = gsrc_q;
          end else begin
            state_d = S_GAPW;
          end
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          src_d   = gsrc_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAPW: begin
        if (cnt_q == TW'(GAP - 1))
          state_d = S_FIRE;
        else
          cnt_d = cnt_q + 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    Rf_B       = 1'b0;
    Busy       = 1'b1;
    Dist_Valid = 1'b0;
    Err        = 1'b0;
    unique case (state_q)
      S_IDLE: Busy       = 1'b0;
      S_FIRE: Rf_B       = 1'b1;
      S_WAIT: Err        = !Rf_Done && tmo_hit;
      S_DONE: Dist_Valid = 1'b1;
      default: ;
    endcase
  end

  assign Dist = dist_q;
  assign Src  = src_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      man_q   <= 1'b0;
      auto_q  <= 1'b0;
      gsrc_q  <= 1'b0;
      sum_q   <= '0;
      scnt_q  <= '0;
      cnt_q   <= '0;
      dist_q  <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      man_q   <= man_d;
      auto_q  <= auto_d;
      gsrc_q  <= gsrc_d;
      sum_q   <= sum_d;
      scnt_q  <= scnt_d;
      cnt_q   <= cnt_d;
      dist_q  <= dist_d;
      src_q   <= src_d;
    end
  end

endmodule

// File: tb/tb_laser_meas_sched.sv
// Bench for laser_meas_sched: table vectors, random averages,
// and hand sequences for timeout, arbitration and reset.
module tb_laser_meas_sched;

  logic        Clk;
  logic        Rst;
  logic        Man_Req;
  logic        Auto_En;
  logic        Rf_B;
  logic        Rf_Done;
  logic [15:0] Rf_D;
  logic        Busy;
  logic [15:0] Dist;
  logic        Dist_Valid;
  logic        Src;
  logic        Err;

  laser_meas_sched #(
    .DW       (16),
    .NAVG_LOG2(2),
    .TIMEOUT  (20),
    .GAP      (2),
    .PERIOD   (100)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Man_Req   (Man_Req),
    .Auto_En   (Auto_En),
    .Rf_B      (Rf_B),
    .Rf_Done   (Rf_Done),
    .Rf_D      (Rf_D),
    .Busy      (Busy),
    .Dist      (Dist),
    .Dist_Valid(Dist_Valid),
    .Src       (Src),
    .Err       (Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int n_chk = 0;
  int n_fail = 0;

  // core model and monitor state
  logic [15:0] resp[$];
  int resp_dly = 5;
  int answer_left = -1;
  int dly = 0;
  int cyc = 0;
  int trig_cnt = 0;
  int last_trig = 0;
  int dbl_b = 0;
  bit prev_b = 0;
  int dv_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  logic [15:0] last_dist;
  logic last_src;
  logic dv_src[$];
  logic [15:0] dv_dist[$];

  typedef struct {
    string nm;
    logic [3:0][15:0] s;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[6];

  function automatic vec_t mk(input string n,
      input logic [15:0] a, input logic [15:0] b,
      input logic [15:0] c, input logic [15:0] d,
      input logic [15:0] e);
    vec_t v;
    v.nm = n;
    v.s = {d, c, b, a};
    v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm,
      input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // One clock: core model drives reply, then outputs sampled.
  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
    Rf_Done = 1'b0;
    if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        Rf_Done = 1'b1;
        Rf_D = (resp.size() > 0) ?
               resp.pop_front() : 16'hDEAD;
      end
    end
    if (Rf_B && answer_left != 0) begin
      dly = resp_dly;
      if (answer_left > 0) answer_left--;
    end
    #1;
    if (Rf_B) begin
      trig_cnt++;
      last_trig = cyc;
      if (prev_b) dbl_b++;
    end
    prev_b = Rf_B;
    if (Dist_Valid) begin
      dv_cnt++;
      last_dist = Dist;
      last_src = Src;
      dv_src.push_back(Src);
      dv_dist.push_back(Dist);
    end
    if (Err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  endtask

  task automatic wait_ev(input int budget, input int dv0,
      input int er0, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dv_cnt != dv0 || err_cnt != er0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic meas_man(input string nm,
      input logic [3:0][15:0] s, input logic [15:0] exp);
    int dv0, er0, tr0;
    bit ok;
    dv0 = dv_cnt;
    er0 = err_cnt;
    tr0 = trig_cnt;
    resp.delete();
    for (int i = 0; i < 4; i++) resp.push_back(s[i]);
    Man_Req = 1'b1;
    tick();
    Man_Req = 1'b0;
    wait_ev(300, dv0, er0, ok);
    chk({nm, "_done"}, 32'(ok), 1);
    chk({nm, "_dist"}, last_dist, exp);
    chk({nm, "_src"}, last_src, 0);
    chk({nm, "_ntrig"}, trig_cnt - tr0, 4);
    chk({nm, "_err"}, err_cnt - er0, 0);
    tick();
    chk({nm, "_busy"}, Busy, 0);
    chk({nm, "_dvcnt"}, dv_cnt - dv0, 1);
  endtask

  task automatic meas_tmo(input string nm, input int ans,
      input int rdly, input int exp_trig);
    int dv0, er0, tr0;
    logic [15:0] d0;
    bit ok;
    dv0 = dv_cnt;
    er0 = err_cnt;
    tr0 = trig_cnt;
    d0 = Dist;
    resp.delete();
    for (int i = 0; i < 4; i++) resp.push_back(16'h0555);
    answer_left = ans;
    resp_dly = rdly;
    Man_Req = 1'b1;
    tick();
    Man_Req = 1'b0;
    wait_ev(300, dv0, er0, ok);
    chk({nm, "_ev"}, 32'(ok), 1);
    chk({nm, "_err"}, err_cnt - er0, 1);
    chk({nm, "_errlat"}, err_cyc - last_trig, 20);
    chk({nm, "_ntrig"}, trig_cnt - tr0, exp_trig);
    tick();
    chk({nm, "_busy"}, Busy, 0);
    chk({nm, "_src"}, Src, 0);
    repeat (6) tick();
    chk({nm, "_nodv"}, dv_cnt - dv0, 0);
    chk({nm, "_dist"}, Dist, d0);
    chk({nm, "_err1"}, err_cnt - er0, 1);
    answer_left = -1;
    resp_dly = 5;
  endtask

  initial begin
    int dv0, tr0;
    bit seen;

    tbl[0] = mk("ramp", 100, 102, 104, 106, 103);
    tbl[1] = mk("max", 16'hFFFF, 16'hFFFF,
                16'hFFFF, 16'hFFFF, 16'hFFFF);
    tbl[2] = mk("trunc", 1, 1, 1, 2, 1);
    tbl[3] = mk("low", 0, 0, 0, 3, 0);
    tbl[4] = mk("half", 7, 8, 9, 10, 8);
    tbl[5] = mk("nearmax", 16'hFFFF, 16'hFFFF,
                16'hFFFF, 16'hFFFC, 16'hFFFE);

    Rst = 1'b1;
    Man_Req = 1'b0;
    Auto_En = 1'b0;
    Rf_Done = 1'b0;
    Rf_D = '0;
    repeat (3) tick();
    chk("rst_rfb", Rf_B, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_dv", Dist_Valid, 0);
    chk("rst_err", Err, 0);
    chk("rst_src", Src, 0);
    chk("rst_dist", Dist, 0);
    Rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 6; i++)
      meas_man(tbl[i].nm, tbl[i].s, tbl[i].exp);

    for (int r = 0; r < 8; r++) begin
      logic [3:0][15:0] s;
      int unsigned sum;
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        s[i] = 16'($urandom);
        sum += s[i];
      end
      repeat ($urandom_range(0, 5)) tick();
      meas_man("rand", s, 16'(sum / 4));
    end

    // second trigger left unanswered
    meas_tmo("tmo2", 1, 5, 2);
    // reply one cycle too late
    meas_tmo("late", -1, 21, 1);

    // reply exactly on the expiry cycle is accepted
    resp_dly = 20;
    meas_man("edge", {16'd503, 16'd502, 16'd501, 16'd500},
             16'd501);
    resp_dly = 5;

    // manual and auto collide; extra manuals merge
    dv_src.delete();
    dv_dist.delete();
    resp.delete();
    for (int i = 0; i < 4; i++) resp.push_back(16'(10 * (i + 1)));
    for (int i = 0; i < 3; i++) resp.push_back(16'd1000);
    resp.push_back(16'd1004);
    for (int i = 0; i < 4; i++) resp.push_back(16'd8);
    dv0 = dv_cnt;
    tr0 = trig_cnt;
    Auto_En = 1'b1;
    repeat (99) tick();
    Man_Req = 1'b1;
    tick();
    Man_Req = 1'b0;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      seen = dv_cnt != dv0;
    end
    chk("arb_first", 32'(seen), 1);
    tick();
    tick();
    chk("arb_auto_busy", Busy, 1);
    Auto_En = 1'b0;
    for (int k = 0; k < 3; k++) begin
      Man_Req = 1'b1;
      tick();
      Man_Req = 1'b0;
      repeat (3) tick();
    end
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      seen = dv_cnt == dv0 + 3;
    end
    chk("arb_three", 32'(seen), 1);
    repeat (80) tick();
    chk("arb_dvcnt", dv_cnt - dv0, 3);
    chk("arb_ntrig", trig_cnt - tr0, 12);
    if (dv_src.size() == 3) begin
      chk("arb_src0", dv_src[0], 0);
      chk("arb_src1", dv_src[1], 1);
      chk("arb_src2", dv_src[2], 0);
      chk("arb_dist0", dv_dist[0], 25);
      chk("arb_dist1", dv_dist[1], 1001);
      chk("arb_dist2", dv_dist[2], 8);
    end
    chk("arb_busy", Busy, 0);

    // reset while waiting on the core
    resp.delete();
    for (int i = 0; i < 4; i++) resp.push_back(16'h0111);
    tr0 = trig_cnt;
    Man_Req = 1'b1;
    tick();
    Man_Req = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      seen = trig_cnt != tr0;
    end
    chk("mrst_trig", 32'(seen), 1);
    tick();
    Rst = 1'b1;
    tick();
    chk("mrst_rfb", Rf_B, 0);
    chk("mrst_busy", Busy, 0);
    chk("mrst_dv", Dist_Valid, 0);
    chk("mrst_err", Err, 0);
    chk("mrst_src", Src, 0);
    chk("mrst_dist", Dist, 0);
    Rst = 1'b0;
    dv0 = dv_cnt;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Busy) seen = 1;
    end
    chk("mrst_idle", 32'(seen), 0);
    chk("mrst_nodv", dv_cnt - dv0, 0);
    meas_man("post_rst", {16'd43, 16'd42, 16'd41, 16'd40},
             16'd41);

    chk("rfb_single", dbl_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/laser_meas_sched.md
Name: laser_meas_sched

Overview:
Measurement scheduler for the laser rangefinder core. Shares the single core between two requesters: a manual request from the debounced button and an auto-repeat timer. For each granted request it fires the core 2^NAVG_LOG2 times, averages the returned distances, and reports the result with its source. A missing echo is caught by a timeout and reported as an error.

Parameters:
DW, 16, distance width from core and of the averaged result
NAVG_LOG2, 2, log2 of samples per measurement (4 samples)
TIMEOUT, 1000, max cycles from trigger to Rf_Done before abort
GAP, 2, idle cycles between Rf_Done and next trigger (core re-arm)
PERIOD, 50000, auto-request interval in cycles

Ports:
Clk  in  1  clock
Rst  in  1  synchronous active-high reset
Man_Req  in  1  1-cycle manual measurement request
Auto_En  in  1  level; enables periodic auto requests
Rf_B  out  1  1-cycle trigger pulse to rangefinder core
Rf_Done  in  1  1-cycle pulse from core: Rf_D valid
Rf_D  in  DW  round-trip-corrected distance from core
Busy  out  1  high while a measurement is in progress
Dist  out  DW  last averaged distance; held until next valid
Dist_Valid  out  1  1-cycle pulse: Dist updated
Src  out  1  source of last result/error: 0 manual, 1 auto
Err  out  1  1-cycle pulse: timeout abort

Behaviour:
- Interface: reset Rst, synchronous, active-high; clock Clk.
- Reset: state IDLE; Rf_B, Busy, Dist_Valid, Err, Src = 0; Dist = 0; pending flags, timer, sum and counters = 0. Reset mid-measurement aborts it with no Err pulse; Rf_B is 0 from the next edge.
- Auto timer: counts 0..PERIOD-1 while Auto_En=1. At terminal count it sets auto_pend and wraps to 0. Auto_En=0 clears the timer and auto_pend. An auto measurement already in progress completes.
- Man_Req sets man_pend. Requests are one deep: repeats while pending or busy merge into the same flag.
- States:
  - IDLE: Busy=0. If man_pend, grant manual; else if auto_pend, grant auto. Manual has fixed priority. On grant: clear that source's flag, latch the granted source, zero sum and sample count, go to FIRE.
  - FIRE: Rf_B=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: the timeout counter increments each cycle.
    - On Rf_Done: sum += Rf_D and count++. If count reaches 2^NAVG_LOG2, go to DONE; else go to GAPW.
    - If the counter reaches TIMEOUT-1 without Rf_Done: go to IDLE, pulse Err, set Src to the granted source, discard sum, leave Dist unchanged.
    - Rf_Done in the same cycle as expiry: Done wins.
  - GAPW: wait GAP cycles, then go to FIRE.
  - DONE: Dist <= sum >> NAVG_LOG2 (truncating), Dist_Valid=1, Src = granted source, go to IDLE.
- Busy=1 in FIRE, WAIT, GAPW and DONE.
- Rf_Done outside WAIT is ignored.
- Accumulator width DW+NAVG_LOG2, so no overflow: 4 x 0xFFFF averages to 0xFFFF.
- Latency, ideal core: grant to first Rf_B = 1 cycle. Requests pending at DONE are granted in the IDLE cycle immediately following.

Decomposition:
- Package laser_pkg: state encoding constants (IDLE, FIRE, WAIT, GAPW, DONE), SRC_MAN/SRC_AUTO, default DW.
- One sub-module: laser_period_timer (auto-request counter with enable and terminal-count pulse).
- Arbitration and the FSM stay in the top module.

Test Plan:
Bench uses TIMEOUT=20, GAP=2, PERIOD=100, NAVG_LOG2=2, and a core model answering 5 cycles after Rf_B.
- Man_Req pulse; model returns 100,102,104,106 -> four single-cycle Rf_B pulses, Dist=103, Dist_Valid 1 cycle, Src=0, Busy low after.
- Model returns 0xFFFF x4 -> Dist=0xFFFF (no overflow); returns 1,1,1,2 -> Dist=1 (truncation).
- Model silent after 2nd trigger -> Err pulse exactly 20 cycles after that Rf_B, Dist unchanged, Dist_Valid never asserted, state IDLE.
- Auto_En=1 with Man_Req in the same cycle as the auto terminal count -> manual serviced first (Src=0), auto immediately after (Src=1); 3 extra Man_Req during busy -> only one additional measurement.
- Rst asserted during WAIT -> next cycle all outputs 0; a late Rf_Done is ignored; a new Man_Req works normally.
- Rf_Done coincident with the timeout cycle -> sample accepted, no Err.
